// File: rtl/inst_mem_pipe.sv
// Purpose : fetch-stage instruction memory with a registered (synchronous) read,
//           a valid/ready request port and a 2-entry response FIFO. Supports
//           wrap-around or out-of-range faulting, misaligned-fetch flagging,
//           a program-load write port and a redirect flush.
// Ports   : clk, rst (async, active-high)
//           req_valid/req_ready/req_addr            - fetch request (byte PC)
//           rsp_valid/rsp_ready/rsp_data/rsp_addr/rsp_fault - FIFO head
//           wr_en/wr_addr/wr_data                   - program-load write
//           flush                                   - drop all buffered responses
module inst_mem_pipe #(
  parameter int unsigned DEPTH     = 32,
  parameter bit          WRAP_MODE = 1'b1,
  parameter logic [31:0] NOP_WORD  = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [31:0] rsp_addr,
  output logic [1:0]  rsp_fault,
  input  logic        wr_en,
  input  logic [31:0] wr_addr,
  input  logic [31:0] wr_data,
  input  logic        flush
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] FAULT_OK  = 2'b00;
  localparam logic [1:0] FAULT_MIS = 2'b01;
  localparam logic [1:0] FAULT_OOR = 2'b10;

  // Storage array: no reset, loaded through the write port.
  logic [31:0] mem_q [DEPTH];

  logic [AW-1:0] rd_idx_c;
  logic [AW-1:0] wr_idx_c;
  logic          mis_c;
  logic          oor_c;
  logic [1:0]    fetch_fault_c;
  logic [31:0]   fetch_data_c;
  logic          push_c;
  logic          pop_c;
  logic          unused_wr_c;

  // Response FIFO state.
  logic [31:0] buf_data_q  [2];
  logic [31:0] buf_data_d  [2];
  logic [31:0] buf_addr_q  [2];
  logic [31:0] buf_addr_d  [2];
  logic [1:0]  buf_fault_q [2];
  logic [1:0]  buf_fault_d [2];
  logic        wr_ptr_q, wr_ptr_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic [1:0]  count_q,  count_d;

  assign rd_idx_c = req_addr[AW+1:2];
  assign wr_idx_c = wr_addr[AW+1:2];

  // Write byte-offset and high bits are ignored; writes always wrap.
  assign unused_wr_c = ^wr_addr;

  // Fault classification and fetched word; misaligned outranks out-of-range.
  always_comb begin
    mis_c         = (req_addr[1:0] != 2'b00);
    oor_c         = !WRAP_MODE && ((req_addr >> (AW + 2)) != 32'd0);
    fetch_fault_c = FAULT_OK;
    if (mis_c) begin
      fetch_fault_c = FAULT_MIS;
    end else if (oor_c) begin
      fetch_fault_c = FAULT_OOR;
    end
    // Asynchronous array read captured at the accept edge gives
    // read-before-write on a same-index collision.
    fetch_data_c = (fetch_fault_c == FAULT_OK) ? mem_q[rd_idx_c] : NOP_WORD;
  end

  // Program-load write port; unaffected by flush and reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_idx_c] <= wr_data;
    end
  end

  // Handshake depends only on registered state and reset.
  assign req_ready = !rst && (count_q < 2'd2);
  assign rsp_valid = (count_q != 2'd0);
  assign push_c    = req_valid && req_ready;
  assign pop_c     = rsp_valid && rsp_ready;

  // FIFO next state; flush overrides both push and pop.
  always_comb begin
    buf_data_d  = buf_data_q;
    buf_addr_d  = buf_addr_q;
    buf_fault_d = buf_fault_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    if (flush) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push_c) begin
        buf_data_d[wr_ptr_q]  = fetch_data_c;
        buf_addr_d[wr_ptr_q]  = req_addr;
        buf_fault_d[wr_ptr_q] = fetch_fault_c;
        wr_ptr_d              = ~wr_ptr_q;
      end
      if (pop_c) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      case ({push_c, pop_c})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  // FIFO registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        buf_data_q[i]  <= 32'd0;
        buf_addr_q[i]  <= 32'd0;
        buf_fault_q[i] <= FAULT_OK;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      buf_data_q  <= buf_data_d;
      buf_addr_q  <= buf_addr_d;
      buf_fault_q <= buf_fault_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  // Response outputs present the FIFO head entry.
  assign rsp_data  = buf_data_q[rd_ptr_q];
  assign rsp_addr  = buf_addr_q[rd_ptr_q];
  assign rsp_fault = buf_fault_q[rd_ptr_q];

endmodule

// File: tb/tb_inst_mem_pipe.sv
// Bench for inst_mem_pipe: two DEPTH=8 instances (wrap and fault mode) share
// the same stimulus; a queue-based reference model predicts both.
module tb_inst_mem_pipe;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        rsp_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        flush;

  logic        rw_req_ready, rw_rsp_valid;
  logic [31:0] rw_rsp_data,  rw_rsp_addr;
  logic [1:0]  rw_rsp_fault;
  logic        rf_req_ready, rf_rsp_valid;
  logic [31:0] rf_rsp_data,  rf_rsp_addr;
  logic [1:0]  rf_rsp_fault;

  inst_mem_pipe #(.DEPTH(8), .WRAP_MODE(1'b1), .NOP_WORD(NOP)) u_wrap (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(rw_req_ready), .req_addr(req_addr),
    .rsp_valid(rw_rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rw_rsp_data),
    .rsp_addr(rw_rsp_addr), .rsp_fault(rw_rsp_fault),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .flush(flush)
  );

  inst_mem_pipe #(.DEPTH(8), .WRAP_MODE(1'b0), .NOP_WORD(NOP)) u_flt (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(rf_req_ready), .req_addr(req_addr),
    .rsp_valid(rf_rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rf_rsp_data),
    .rsp_addr(rf_rsp_addr), .rsp_fault(rf_rsp_fault),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .flush(flush)
  );

  always #5 clk = ~clk;

  // Reference model: word array plus a queue of expected responses.
  typedef struct {
    logic [31:0] addr;
    logic [31:0] dw;
    logic [1:0]  fw;
    logic [31:0] df;
    logic [1:0]  ff;
  } ent_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] dw;
    logic [1:0]  fw;
    logic [31:0] df;
    logic [1:0]  ff;
  } vec_t;

  logic [31:0] ref_mem [8];
  ent_t        mq [$];
  int          n_chk;
  int          n_err;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endfunction

  function automatic ent_t predict(logic [31:0] a);
    ent_t e;
    logic mis;
    logic oor;
    mis    = (a % 4) != 0;
    oor    = (a / 32) != 0;
    e.addr = a;
    e.fw   = mis ? 2'b01 : 2'b00;
    e.dw   = mis ? NOP : ref_mem[(a / 4) % 8];
    e.ff   = mis ? 2'b01 : (oor ? 2'b10 : 2'b00);
    e.df   = (e.ff != 2'b00) ? NOP : ref_mem[(a / 4) % 8];
    return e;
  endfunction

  function automatic void compare_all();
    chk("wrap_valid", 32'(rw_rsp_valid), 32'(mq.size() != 0));
    chk("flt_valid",  32'(rf_rsp_valid), 32'(mq.size() != 0));
    chk("wrap_ready", 32'(rw_req_ready), 32'(!rst && mq.size() < 2));
    chk("flt_ready",  32'(rf_req_ready), 32'(!rst && mq.size() < 2));
    if (mq.size() != 0) begin
      chk("wrap_data",  rw_rsp_data,         mq[0].dw);
      chk("wrap_addr",  rw_rsp_addr,         mq[0].addr);
      chk("wrap_fault", 32'(rw_rsp_fault),   32'(mq[0].fw));
      chk("flt_data",   rf_rsp_data,         mq[0].df);
      chk("flt_addr",   rf_rsp_addr,         mq[0].addr);
      chk("flt_fault",  32'(rf_rsp_fault),   32'(mq[0].ff));
    end
  endfunction

  // One clock: predict, advance model at the edge, compare #1 later.
  task automatic cyc();
    ent_t e;
    bit   acc;
    bit   pop;
    e   = predict(req_addr);
    acc = !rst && req_valid && (mq.size() < 2);
    pop = (mq.size() != 0) && rsp_ready;
    @(posedge clk);
    if (flush) begin
      mq.delete();
    end else begin
      if (pop) mq.delete(0);
      if (acc) mq.push_back(e);
    end
    if (wr_en) ref_mem[(wr_addr / 4) % 8] = wr_data;
    #1;
    compare_all();
  endtask

  task automatic chk_reset_outputs(string tag);
    chk({tag, "_wvalid"}, 32'(rw_rsp_valid), 32'd0);
    chk({tag, "_fvalid"}, 32'(rf_rsp_valid), 32'd0);
    chk({tag, "_wdata"},  rw_rsp_data,       32'd0);
    chk({tag, "_waddr"},  rw_rsp_addr,       32'd0);
    chk({tag, "_wfault"}, 32'(rw_rsp_fault), 32'd0);
    chk({tag, "_fdata"},  rf_rsp_data,       32'd0);
    chk({tag, "_wready"}, 32'(rw_req_ready), 32'd0);
    chk({tag, "_fready"}, 32'(rf_req_ready), 32'd0);
  endtask

  vec_t tbl [7];

  initial begin
    tbl[0] = '{addr: 32'd32,         dw: 32'h1000_0000, fw: 2'b00, df: NOP,          ff: 2'b10};
    tbl[1] = '{addr: 32'd52,         dw: 32'h1000_0005, fw: 2'b00, df: NOP,          ff: 2'b10};
    tbl[2] = '{addr: 32'd6,          dw: NOP,           fw: 2'b01, df: NOP,          ff: 2'b01};
    tbl[3] = '{addr: 32'd34,         dw: NOP,           fw: 2'b01, df: NOP,          ff: 2'b01};
    tbl[4] = '{addr: 32'd28,         dw: 32'h1000_0007, fw: 2'b00, df: 32'h1000_0007, ff: 2'b00};
    tbl[5] = '{addr: 32'hFFFF_FFFC,  dw: 32'h1000_0007, fw: 2'b00, df: NOP,          ff: 2'b10};
    tbl[6] = '{addr: 32'd8,          dw: 32'h1000_0002, fw: 2'b00, df: 32'h1000_0002, ff: 2'b00};

    n_chk = 0; n_err = 0;
    clk = 1'b0; rst = 1'b1;
    req_valid = 1'b0; req_addr = 32'd0; rsp_ready = 1'b0;
    wr_en = 1'b0; wr_addr = 32'd0; wr_data = 32'd0; flush = 1'b0;

    // Reset values, then ready in the same cycle reset drops.
    #1;
    chk_reset_outputs("por");
    #11;
    rst = 1'b0;
    #1;
    chk("por_rel_ready", 32'(rw_req_ready), 32'd1);
    chk("por_rel_valid", 32'(rw_rsp_valid), 32'd0);

    // Program load.
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; wr_addr = 32'(i * 4); wr_data = 32'h1000_0000 + 32'(i);
      cyc();
    end
    wr_en = 1'b0;

    // Linear back-to-back fetch, one response per cycle.
    rsp_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      req_valid = 1'b1; req_addr = 32'(k * 4);
      cyc();
      chk("lin_data",  rw_rsp_data, 32'h1000_0000 + 32'(k));
      chk("lin_fault", 32'(rw_rsp_fault), 32'd0);
    end
    req_valid = 1'b0;
    cyc();

    // Table of single fetches: wrap, fault, misaligned priority.
    for (int i = 0; i < 7; i++) begin
      req_valid = 1'b1; req_addr = tbl[i].addr;
      cyc();
      req_valid = 1'b0;
      chk("tbl_wdata",  rw_rsp_data,        tbl[i].dw);
      chk("tbl_wfault", 32'(rw_rsp_fault),  32'(tbl[i].fw));
      chk("tbl_fdata",  rf_rsp_data,        tbl[i].df);
      chk("tbl_ffault", 32'(rf_rsp_fault),  32'(tbl[i].ff));
      chk("tbl_faddr",  rf_rsp_addr,        tbl[i].addr);
    end
    cyc();

    // Backpressure: only two accepted, outputs hold, then drain in order.
    rsp_ready = 1'b0; req_valid = 1'b1;
    req_addr = 32'd0; cyc();
    req_addr = 32'd4; cyc();
    chk("bp_ready", 32'(rw_req_ready), 32'd0);
    req_addr = 32'd8; cyc();
    chk("bp_hold1", rw_rsp_data, 32'h1000_0000);
    cyc();
    chk("bp_hold2", rw_rsp_data, 32'h1000_0000);
    rsp_ready = 1'b1; cyc();
    chk("bp_head1", rw_rsp_data, 32'h1000_0001);
    cyc();
    chk("bp_head2", rw_rsp_data, 32'h1000_0002);
    req_valid = 1'b0; cyc();
    chk("bp_empty", 32'(rw_rsp_valid), 32'd0);

    // Read/write collision returns old data.
    wr_en = 1'b1; wr_addr = 32'd12; wr_data = 32'hAAAA_0003; cyc();
    wr_data = 32'hBBBB_0003; req_valid = 1'b1; req_addr = 32'd12; cyc();
    chk("col_old", rw_rsp_data, 32'hAAAA_0003);
    wr_en = 1'b0; cyc();
    chk("col_new", rw_rsp_data, 32'hBBBB_0003);
    req_valid = 1'b0; cyc();

    // Flush with two buffered, then flush winning over a same-edge accept.
    rsp_ready = 1'b0; req_valid = 1'b1;
    req_addr = 32'd0; cyc();
    req_addr = 32'd4; cyc();
    flush = 1'b1; req_addr = 32'd8; cyc();
    flush = 1'b0; req_valid = 1'b0;
    chk("fl_valid", 32'(rw_rsp_valid), 32'd0);
    req_valid = 1'b1; req_addr = 32'd0; cyc();
    flush = 1'b1; req_addr = 32'd8; cyc();
    flush = 1'b0; req_valid = 1'b0;
    chk("fl2_valid", 32'(rw_rsp_valid), 32'd0);
    cyc();
    chk("fl2_idle", 32'(rf_rsp_valid), 32'd0);

    // Asynchronous reset mid-stream; memory survives.
    req_valid = 1'b1; req_addr = 32'd0; cyc();
    req_addr = 32'd4; cyc();
    #2;
    rst = 1'b1;
    #1;
    chk_reset_outputs("arst");
    mq.delete();
    @(posedge clk);
    #1;
    chk_reset_outputs("arst_hold");
    rst = 1'b0;
    #1;
    chk("arst_rel_ready", 32'(rw_req_ready), 32'd1);
    chk("arst_rel_valid", 32'(rf_rsp_valid), 32'd0);
    rsp_ready = 1'b1; req_addr = 32'd0; cyc();
    chk("arst_mem", rw_rsp_data, 32'h1000_0000);
    req_valid = 1'b0; cyc();

    // Randomised traffic against the model.
    for (int n = 0; n < 400; n++) begin
      int unsigned r;
      r = $urandom_range(0, 9);
      if (r < 6)       req_addr = 32'($urandom_range(0, 15) * 4);
      else if (r < 8)  req_addr = 32'($urandom_range(0, 63));
      else if (r < 9)  req_addr = $urandom;
      else             req_addr = $urandom & 32'hFFFF_FFFC;
      req_valid = ($urandom_range(0, 3) != 0);
      rsp_ready = ($urandom_range(0, 2) != 0);
      wr_en     = ($urandom_range(0, 7) == 0);
      wr_addr   = $urandom;
      wr_data   = $urandom;
      flush     = ($urandom_range(0, 19) == 0);
      cyc();
    end
    req_valid = 1'b0; wr_en = 1'b0; flush = 1'b0;
    cyc();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/inst_mem_pipe.md
Name: inst_mem_pipe

Overview:
Parametrised instruction memory for the fetch stage, replacing the single-cycle combinational InstMem. It uses a synchronous read with a valid/ready request port and a 2-entry response buffer. Address handling is configurable: wrap-around or fault. Misaligned fetches are flagged, a write port allows program loading, and a flush drops pending responses on a redirect. It sits between the PC/fetch logic and the IF/ID register.

Parameters:
DEPTH, 32, number of 32-bit words; power of two, minimum 2
WRAP_MODE, 1, 1 = index is addr modulo DEPTH words; 0 = addresses at or above DEPTH*4 return a fault
NOP_WORD, 32'h00000013, data returned on any faulted fetch (addi x0,x0,0)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
req_valid  input  1  fetch request valid
req_ready  output  1  block can accept a request
req_addr  input  32  byte address (PC)
rsp_valid  output  1  response at buffer head is valid
rsp_ready  input  1  consumer accepts the response
rsp_data  output  32  instruction word
rsp_addr  output  32  byte address of the returned word
rsp_fault  output  2  00 ok, 01 misaligned, 10 out of range
wr_en  input  1  program-load write enable
wr_addr  input  32  write byte address; bits [1:0] ignored
wr_data  input  32  write word
flush  input  1  synchronous drop of all buffered responses

Behaviour:
- Index is addr[$clog2(DEPTH)+1:2]. Writes always use this index, so writes wrap regardless of WRAP_MODE.
- Out of range means WRAP_MODE=0 and addr[31:$clog2(DEPTH)+2] != 0.
- Fault priority: misaligned (addr[1:0] != 0) wins over out of range. Any faulted response carries rsp_data=NOP_WORD and the original rsp_addr.
- Accept means req_valid & req_ready at a rising edge. On that edge the array is read and {data, addr, fault} is pushed into the 2-entry FIFO.
- Latency: 1 cycle from accept to rsp_valid.
- req_ready = !rst & (count < 2). It depends only on registered state; there is no combinational path from rsp_ready.
- rsp_valid = (count != 0). The rsp_* outputs show the FIFO head. A pop occurs on rsp_valid & rsp_ready.
- Push and pop may happen on the same edge: count is unchanged and order is preserved. Sustained throughput is 1 fetch per cycle when rsp_ready=1.
- Full (count=2): req_ready=0 and no push. Empty: rsp_valid=0, and rsp_ready is ignored.
- While rsp_valid=1 and rsp_ready=0, the rsp_* outputs hold stable.
- Write: on an edge with wr_en=1, mem[index] <= wr_data.
- Read/write collision: an accept and a write to the same index on the same edge return the OLD data (read-before-write).
- Flush: on an edge with flush=1, count <= 0 and both pointers reset. A request accepted on that same edge is dropped (flush wins), and any same-edge pop is irrelevant. rsp_valid=0 in the following cycle. Writes are unaffected by flush.
- Reset (asynchronous, any time, including mid-transfer):
  - count=0, pointers=0, rsp_valid=0, rsp_data=0, rsp_addr=0, rsp_fault=00, req_ready=0 while rst=1.
  - Memory contents are not reset.
  - After rst deasserts, req_ready=1 in the same cycle.
- The array is a plain register array with no reset, inferable as distributed RAM. Simulation initialisation is loaded from the bench through the write port.

Test Plan:
- Linear fetch, DEPTH=8, WRAP_MODE=1: load mem[i]=32'h1000_0000+i, then issue addr 0,4,...,28 back-to-back with rsp_ready=1 -> rsp_data 10000000..10000007, one per cycle, each 1 cycle after accept, rsp_fault=00.
- Wrap vs fault: DEPTH=8, WRAP_MODE=1, addr 32 and 52 -> 10000000 and 10000005, fault 00. WRAP_MODE=0, addr 32 -> rsp_data=00000013, rsp_fault=10, rsp_addr=32.
- Misaligned: addr 6 with either mode -> fault 01, data 00000013. Addr 34 with WRAP_MODE=0 -> fault 01 (priority over 10).
- Backpressure: rsp_ready=0, req_valid held with addr 0,4,8 -> only 0 and 4 accepted, req_ready=0 after 2 accepts, outputs stable. Raise rsp_ready -> 10000000, 10000001, then 10000002 in order, with no loss or duplication.
- Collision: mem[3]=AAAA0003, then on the same edge wr_en with wr_addr=12, wr_data=BBBB0003 and accept addr 12 -> response AAAA0003. Next fetch of 12 -> BBBB0003.
- Flush and reset: 2 responses buffered, then flush together with a new accept -> rsp_valid=0 next cycle, and the new request is not returned. Assert rst asynchronously mid-stream -> rsp_valid=0, rsp_*=0, req_ready=0 immediately. Memory keeps its contents after reset, and re-fetching addr 0 returns 10000000.
